ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Fetch sequencer for the IF stage.
- Drives the PC-select / PC-write / IF-ID-write / flush controls of the PC register and IF/ID pipeline register.
- Performs a req/ack handshake with variable-latency instruction memory.
- Holds a 1-entry skid buffer so an instruction returned during a back-end stall is never lost.
- Defers control-flow redirects that arrive while a fetch is outstanding.

Parameters:
DATA_W, 32, instruction width
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset
im_req  out  1  fetch request to instruction memory at current PC
im_ack  in  1  single-cycle pulse: im_rdata valid, request complete
im_rdata  in  DATA_W  fetched instruction
load_use  in  1  load-use hazard from ID
be_stall  in  1  back-end (data memory) stall
jump_imm  in  1  taken branch/JAL in EX, target PC+imm
jump_reg  in  1  JALR in EX, target rs1+imm
pc_write  out  1  PC register enable
branch_ctrl  out  2  PC select: 2'b10 PC+4, 2'b01 PC+imm, 2'b00 rs1+imm
ifid_write  out  1  IF/ID register enable
instr_flush  out  1  IF/ID loads NOP (0) instead of instr_out
instr_out  out  DATA_W  instruction to IF/ID: skid when state==BUFD, else im_rdata
ex_hold  out  1  freeze EX so redirect/target inputs stay stable

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
- Reset values: state IDLE; im_req, pc_write, ifid_write, instr_flush, ex_hold = 0; branch_ctrl = 2'b10; skid = 0; pend = 0.
- Signal definitions: hold = load_use | be_stall. redir = (jump_imm | jump_reg) & ~be_stall. jump_reg has priority over jump_imm. Target kind k = 2'b00 for jump_reg, 2'b01 for jump_imm.
- Outputs are combinational from state and inputs. Any cycle not listed below drives pc_write = ifid_write = instr_flush = 0, branch_ctrl = 2'b10.
- The PC may change only on a cycle with pc_write = 1. im_req stays high until im_ack; the address must be stable while a request is outstanding.

IDLE:
- All control outputs 0.
- Unconditionally go to FETCH next cycle.

FETCH:
- im_req = 1.
- im_ack & redir: pc_write = 1, branch_ctrl = k, ifid_write = 1, instr_flush = 1 (the fetched instruction is wrong-path). Stay in FETCH.
- im_ack & ~redir & ~hold: pc_write = 1, branch_ctrl = 2'b10, ifid_write = 1, instr_flush = 0. Stay in FETCH.
- im_ack & ~redir & hold: skid <= im_rdata, pc_write = 0 (PC keeps the buffered instruction's address). Go to BUFD.
- ~im_ack & redir: pend <= k, ex_hold = 1. Go to REDIR.
- ~im_ack & ~redir: wait, no enables.

BUFD:
- im_req = 0.
- redir: pc_write = 1, branch_ctrl = k, ifid_write = 1, instr_flush = 1. Go to FETCH.
- ~redir & ~hold: ifid_write = 1 (instr_out = skid), pc_write = 1, branch_ctrl = 2'b10. Go to FETCH.
- Otherwise remain in BUFD.

REDIR:
- im_req = 1, ex_hold = 1, jump inputs ignored.
- On im_ack: discard im_rdata, pc_write = 1, branch_ctrl = pend, ifid_write = 1, instr_flush = 1, ex_hold = 0. Go to FETCH.

Ordering and edge cases:
- load_use does not block a redirect: the instruction in ID is wrong-path.
- be_stall defers a redirect: EX has not resolved.
- Reset mid-fetch drops any outstanding request; the memory side must tolerate a late ack after reset. An ack arriving in IDLE is ignored.
- Back-to-back zero-wait acks yield one IF/ID write per cycle.

Optional Feature:
IFETCH_PERF_EN: defined → adds three outputs, each CNT_W wide, reset to 0 and wrapping at 2^CNT_W:
- fetch_cnt: IF/ID writes with instr_flush = 0
- stall_cnt: cycles in FETCH without ack, plus cycles in BUFD or REDIR
- flush_cnt: IF/ID writes with instr_flush = 1

Undefined → these ports and registers are absent; behaviour otherwise identical.

Test Plan:
- Zero-wait memory (im_ack = 1 every cycle from the cycle after reset release), no hazards → pc_write = ifid_write = 1 every cycle, branch_ctrl = 2'b10, instr_out tracks im_rdata, instr_flush = 0.
- Ack with im_rdata = 32'h00A00093 while be_stall = 1 for 3 cycles → BUFD, im_req = 0, pc_write = 0 for 3 cycles. First cycle with be_stall = 0: ifid_write = 1, instr_out = 32'h00A00093, pc_write = 1.
- jump_imm = 1 in the same cycle as im_ack → pc_write = 1, branch_ctrl = 2'b01, ifid_write = 1, instr_flush = 1; next cycle normal fetch.
- jump_reg = 1 two cycles before im_ack (3-cycle memory latency) → ex_hold = 1 until the ack cycle. In the ack cycle: branch_ctrl = 2'b00, pc_write = 1, instr_flush = 1, ex_hold = 0.
- jump_imm = 1 together with be_stall = 1 → no redirect. be_stall drops → redirect taken in that cycle.
- rst asserted while in REDIR → all outputs return to reset values immediately; one IDLE cycle after release, then im_req = 1.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch sequencer for the IF stage.
//
// Runs the req/ack handshake with a variable-latency instruction memory and
// drives the PC and IF/ID pipeline-register controls. A one-entry skid buffer
// holds an instruction that returns while the back end is stalled. A redirect
// that arrives while a fetch is outstanding is recorded and applied when the
// in-flight fetch completes. EX is frozen until then so the target stays stable.
//
// Optional feature: define IFETCH_PERF_EN to add the fetch_cnt, stall_cnt and
// flush_cnt performance counters.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   im_req       fetch request at the current PC (held until im_ack)
//   im_ack       one-cycle completion pulse; im_rdata is valid with it
//   im_rdata     fetched instruction
//   load_use     load-use hazard from ID
//   be_stall     back-end stall
//   jump_imm     taken branch/JAL in EX (target PC+imm)
//   jump_reg     JALR in EX (target rs1+imm); has priority over jump_imm
//   pc_write     PC register enable
//   branch_ctrl  PC select: 2'b10 PC+4, 2'b01 PC+imm, 2'b00 rs1+imm
//   ifid_write   IF/ID register enable
//   instr_flush  IF/ID loads a NOP instead of instr_out
//   instr_out    instruction for IF/ID (skid buffer in BUFD, else im_rdata)
//   ex_hold      freeze EX while a deferred redirect is pending
//   fetch_cnt, stall_cnt, flush_cnt  performance counters (IFETCH_PERF_EN only)
module ifetch_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              im_req,
    input  logic              im_ack,
    input  logic [DATA_W-1:0] im_rdata,
    input  logic              load_use,
    input  logic              be_stall,
    input  logic              jump_imm,
    input  logic              jump_reg,
    output logic              pc_write,
    output logic [1:0]        branch_ctrl,
    output logic              ifid_write,
    output logic              instr_flush,
    output logic [DATA_W-1:0] instr_out,
`ifdef IFETCH_PERF_EN
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic              ex_hold
);

    localparam logic [1:0] SelPc4 = 2'b10;

    typedef enum logic [1:0] {StIdle, StFetch, StBufd, StRedir} state_e;

    state_e            state;
    logic [DATA_W-1:0] skid;
    logic [1:0]        pend;

    logic       hold;
    logic       redir;
    logic [1:0] kind;

    // Counters are sized by CNT_W; a zero width is meaningless.
    if (CNT_W == 0) begin : g_cnt_w_check
        $error("ifetch_ctrl: CNT_W must be at least 1");
    end

    assign hold  = load_use | be_stall;
    // EX has not resolved while the back end is stalled, so the jump waits.
    assign redir = (jump_imm | jump_reg) & ~be_stall;
    assign kind  = jump_reg ? 2'b00 : 2'b01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            skid  <= '0;
            pend  <= 2'b00;
        end else begin
            unique case (state)
                StIdle: state <= StFetch;
                StFetch: begin
                    if (im_ack) begin
                        if (!redir && hold) begin
                            skid  <= im_rdata;
                            state <= StBufd;
                        end
                    end else if (redir) begin
                        pend  <= kind;
                        state <= StRedir;
                    end
                end
                StBufd: begin
                    if (redir || !hold) state <= StFetch;
                end
                StRedir: begin
                    if (im_ack) state <= StFetch;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        im_req      = 1'b0;
        pc_write    = 1'b0;
        branch_ctrl = SelPc4;
        ifid_write  = 1'b0;
        instr_flush = 1'b0;
        ex_hold     = 1'b0;
        instr_out   = (state == StBufd) ? skid : im_rdata;
        unique case (state)
            StIdle: ;
            StFetch: begin
                im_req = 1'b1;
                if (im_ack) begin
                    if (redir) begin
                        // The returned instruction is wrong-path.
                        pc_write    = 1'b1;
                        branch_ctrl = kind;
                        ifid_write  = 1'b1;
                        instr_flush = 1'b1;
                    end else if (!hold) begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end else if (redir) begin
                    ex_hold = 1'b1;
                end
            end
            StBufd: begin
                if (redir) begin
                    pc_write    = 1'b1;
                    branch_ctrl = kind;
                    ifid_write  = 1'b1;
                    instr_flush = 1'b1;
                end else if (!hold) begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                end
            end
            StRedir: begin
                im_req = 1'b1;
                if (im_ack) begin
                    pc_write    = 1'b1;
                    branch_ctrl = pend;
                    ifid_write  = 1'b1;
                    instr_flush = 1'b1;
                end else begin
                    ex_hold = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef IFETCH_PERF_EN
    logic stall_cycle;

    assign stall_cycle = ((state == StFetch) && !im_ack) || (state == StBufd) ||
                         (state == StRedir);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ifid_write && !instr_flush) fetch_cnt <= fetch_cnt + 1'b1;
            if (ifid_write && instr_flush)  flush_cnt <= flush_cnt + 1'b1;
            if (stall_cycle)                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl. Inputs change 1 ns after the rising edge;
// outputs are sampled 1 ns later, well away from the next edge.
module tb_ifetch_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              im_req;
    logic              im_ack;
    logic [DATA_W-1:0] im_rdata;
    logic              load_use;
    logic              be_stall;
    logic              jump_imm;
    logic              jump_reg;
    logic              pc_write;
    logic [1:0]        branch_ctrl;
    logic              ifid_write;
    logic              instr_flush;
    logic [DATA_W-1:0] instr_out;
    logic              ex_hold;
`ifdef IFETCH_PERF_EN
    logic [CNT_W-1:0]  fetch_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .im_req     (im_req),
        .im_ack     (im_ack),
        .im_rdata   (im_rdata),
        .load_use   (load_use),
        .be_stall   (be_stall),
        .jump_imm   (jump_imm),
        .jump_reg   (jump_reg),
        .pc_write   (pc_write),
        .branch_ctrl(branch_ctrl),
        .ifid_write (ifid_write),
        .instr_flush(instr_flush),
        .instr_out  (instr_out),
`ifdef IFETCH_PERF_EN
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
`endif
        .ex_hold    (ex_hold)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the full control bundle.
    task automatic ctl(input string tag, input logic req, input logic pcw, input logic [1:0] bc,
                       input logic ifw, input logic fl, input logic eh);
        chk({tag, ".im_req"},      32'(im_req),      32'(req));
        chk({tag, ".pc_write"},    32'(pc_write),    32'(pcw));
        chk({tag, ".branch_ctrl"}, 32'(branch_ctrl), 32'(bc));
        chk({tag, ".ifid_write"},  32'(ifid_write),  32'(ifw));
        chk({tag, ".instr_flush"}, 32'(instr_flush), 32'(fl));
        chk({tag, ".ex_hold"},     32'(ex_hold),     32'(eh));
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; im_ack = 1'b0; im_rdata = '0; load_use = 1'b0;
        be_stall = 1'b0; jump_imm = 1'b0; jump_reg = 1'b0;
        cyc();
        #1;
        ctl("reset", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);

        // Release reset: one IDLE cycle; an ack here is ignored.
        cyc();
        rst = 1'b0; im_ack = 1'b1; im_rdata = 32'h1111_0000;
        #1;
        ctl("idle_ack", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);

        // Zero-wait memory, no hazards.
        for (int i = 0; i < 3; i++) begin
            cyc();
            im_rdata = 32'h1000_0001 + 32'(i);
            #1;
            ctl($sformatf("zw%0d", i), 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
            chk($sformatf("zw%0d.instr_out", i), instr_out, 32'h1000_0001 + 32'(i));
        end

        // Ack during back-end stall -> skid buffer.
        cyc();
        im_rdata = 32'h00A0_0093; be_stall = 1'b1;
        #1;
        ctl("skid_ack", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            im_ack = 1'b0; im_rdata = 32'hDEAD_BEEF;
            #1;
            ctl($sformatf("bufd%0d", i), 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        end
        cyc();
        be_stall = 1'b0;
        #1;
        ctl("bufd_rel", 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        chk("bufd_rel.instr_out", instr_out, 32'h00A0_0093);

        // Back in FETCH: jump_imm together with the ack.
        cyc();
        im_ack = 1'b1; im_rdata = 32'h2222_2222; jump_imm = 1'b1;
        #1;
        ctl("jimm_ack", 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        cyc();
        jump_imm = 1'b0; im_rdata = 32'h3333_3333;
        #1;
        ctl("after_jimm", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        chk("after_jimm.instr_out", instr_out, 32'h3333_3333);

        // jump_reg beats jump_imm.
        cyc();
        jump_imm = 1'b1; jump_reg = 1'b1;
        #1;
        ctl("prio", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);

        // Deferred JALR with a 3-cycle memory latency.
        cyc();
        im_ack = 1'b0; jump_imm = 1'b0; jump_reg = 1'b1;
        #1;
        ctl("defer0", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        cyc();
        #1;
        ctl("defer1", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        cyc();
        im_ack = 1'b1; jump_reg = 1'b0; jump_imm = 1'b1; // ignored in REDIR
        #1;
        ctl("defer_ack", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);

        // jump_imm while be_stall: deferred until the stall drops.
        cyc();
        im_ack = 1'b0; jump_imm = 1'b1; be_stall = 1'b1;
        #1;
        ctl("bs_jimm", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc();
        im_ack = 1'b1; be_stall = 1'b0;
        #1;
        ctl("bs_drop", 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);

        // In BUFD: be_stall blocks the jump, load_use does not.
        cyc();
        jump_imm = 1'b0; im_rdata = 32'h4444_4444; be_stall = 1'b1;
        #1;
        ctl("skid2_ack", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc();
        im_ack = 1'b0; jump_imm = 1'b1;
        #1;
        ctl("bufd_bs_jimm", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc();
        be_stall = 1'b0; load_use = 1'b1;
        #1;
        ctl("bufd_lu_jimm", 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0);

        // Reset while in REDIR.
        cyc();
        load_use = 1'b0; jump_imm = 1'b0; jump_reg = 1'b1;
        #1;
        ctl("to_redir", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        cyc();
        jump_reg = 1'b0;
        #1;
        ctl("in_redir", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        ctl("rst_redir", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0; im_ack = 1'b1; // late ack after reset
        #1;
        ctl("post_rst_idle", 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc();
        im_ack = 1'b0;
        #1;
        ctl("post_rst_fetch", 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
